pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. It turns per-stage stall requests into the freeze/bubble vector that drives `pc_reg`, `if_id`, `id_ex`, `ex_mem` and `mem_wb`. It also sequences exception and ERET flushes through a small FSM, and watches for stuck stalls. It sits beside the datapath, with one control output to every pipeline register and to the PC generator.

---
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Stall-request / exception / freeze-vector bundle between the
//               datapath (master) and the pipeline controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int N_INST_ADDR = 32
);
    logic                   i_stallreq_if;
    logic                   i_stallreq_id;
    logic                   i_stallreq_ex;
    logic                   i_stallreq_mem;
    logic                   i_excp_valid;
    logic                   i_excp_eret;
    logic [N_INST_ADDR-1:0] i_epc;
    logic [5:0]             o_stall;
    logic                   o_flush;
    logic [N_INST_ADDR-1:0] o_new_pc;
    logic                   o_stall_timeout;
    logic [31:0]            o_stall_cycles;
    logic [15:0]            o_flush_count;

    modport master (
        output i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
        output i_excp_valid, i_excp_eret, i_epc,
        input  o_stall, o_flush, o_new_pc, o_stall_timeout,
        input  o_stall_cycles, o_flush_count
    );

    modport slave (
        input  i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
        input  i_excp_valid, i_excp_eret, i_epc,
        output o_stall, o_flush, o_new_pc, o_stall_timeout,
        output o_stall_cycles, o_flush_count
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : 5-stage pipeline controller: stall priority, flush/refill FSM,
//               stuck-stall watchdog. PIPE_CTRL_PERF_EN adds perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int                     N_INST_ADDR = 32,
    parameter logic [N_INST_ADDR-1:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int                     TIMEOUT     = 1024
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst_n,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    state_t                 r_state;
    logic                   r_flush;
    logic [N_INST_ADDR-1:0] r_new_pc;
    logic [15:0]            r_wd_cnt;
    logic                   r_timeout;
    logic [5:0]             w_req_stall;
    logic [5:0]             w_stall;
    logic                   w_wd_active;
    logic [15:0]            w_wd_next;
    logic                   w_flush_entry;

    always_comb begin
        w_req_stall = 6'b000000;
        if (bus.i_stallreq_mem)     w_req_stall = 6'b011111;
        else if (bus.i_stallreq_ex) w_req_stall = 6'b001111;
        else if (bus.i_stallreq_id) w_req_stall = 6'b000111;
        else if (bus.i_stallreq_if) w_req_stall = 6'b000011;

        // An exception in RUN pre-empts all stalls so the flush is not held off.
        w_stall = 6'b000000;
        case (r_state)
            ST_RUN:    if (!bus.i_excp_valid) w_stall = w_req_stall;
            ST_REFILL: w_stall = 6'b000001;
            default:   w_stall = 6'b000000;
        endcase
    end

    assign w_flush_entry = (r_state == ST_RUN) && bus.i_excp_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.i_excp_valid) begin
                        r_state  <= ST_FLUSH;
                        r_flush  <= 1'b1;
                        r_new_pc <= bus.i_excp_eret ? bus.i_epc : EXC_VECTOR;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_REFILL;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign w_wd_active = (r_state == ST_RUN) && (w_stall != 6'b000000);
    assign w_wd_next   = (r_wd_cnt == c_timeout) ? r_wd_cnt : r_wd_cnt + 16'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd_cnt  <= 16'd0;
            r_timeout <= 1'b0;
        end else if (w_wd_active) begin
            r_wd_cnt <= w_wd_next;
            if (w_wd_next == c_timeout) r_timeout <= 1'b1;
        end else begin
            r_wd_cnt <= 16'd0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (w_stall != 6'b000000) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_flush_entry)        r_flush_count  <= r_flush_count + 16'd1;
        end
    end

    assign bus.o_stall_cycles = r_stall_cycles;
    assign bus.o_flush_count  = r_flush_count;
`else
    logic w_unused_entry;
    assign w_unused_entry     = w_flush_entry;
    assign bus.o_stall_cycles = 32'd0;
    assign bus.o_flush_count  = 16'd0;
`endif

    assign bus.o_stall         = w_stall;
    assign bus.o_flush         = r_flush;
    assign bus.o_new_pc        = r_new_pc;
    assign bus.o_stall_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed vector-table and sequence bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pipe_ctrl_if #(.N_INST_ADDR(32)) bus ();

    pipe_ctrl #(
        .N_INST_ADDR (32),
        .EXC_VECTOR  (32'h0000_0020),
        .TIMEOUT     (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;   // {mem, ex, id, if}
        logic       excp;
        logic [5:0] exp_stall;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        bus.i_stallreq_mem = r[3];
        bus.i_stallreq_ex  = r[2];
        bus.i_stallreq_id  = r[1];
        bus.i_stallreq_if  = r[0];
    endtask

    logic [15:0] fc_before;

    initial begin
        checks = 0;
        errors = 0;
        set_req(4'b0000);
        bus.i_excp_valid = 1'b0;
        bus.i_excp_eret  = 1'b0;
        bus.i_epc        = 32'h0;

        vecs[0]  = '{4'b0000, 1'b0, 6'b000000};
        vecs[1]  = '{4'b0001, 1'b0, 6'b000011};
        vecs[2]  = '{4'b0010, 1'b0, 6'b000111};
        vecs[3]  = '{4'b0011, 1'b0, 6'b000111};
        vecs[4]  = '{4'b0100, 1'b0, 6'b001111};
        vecs[5]  = '{4'b0101, 1'b0, 6'b001111};
        vecs[6]  = '{4'b0110, 1'b0, 6'b001111};
        vecs[7]  = '{4'b0111, 1'b0, 6'b001111};
        vecs[8]  = '{4'b1000, 1'b0, 6'b011111};
        vecs[9]  = '{4'b1001, 1'b0, 6'b011111};
        vecs[10] = '{4'b1010, 1'b0, 6'b011111};
        vecs[11] = '{4'b1011, 1'b0, 6'b011111};
        vecs[12] = '{4'b1100, 1'b0, 6'b011111};
        vecs[13] = '{4'b1101, 1'b0, 6'b011111};
        vecs[14] = '{4'b1110, 1'b0, 6'b011111};
        vecs[15] = '{4'b1111, 1'b0, 6'b011111};
        vecs[16] = '{4'b1111, 1'b1, 6'b000000};
        vecs[17] = '{4'b0001, 1'b1, 6'b000000};
        vecs[18] = '{4'b0100, 1'b1, 6'b000000};
        vecs[19] = '{4'b0000, 1'b1, 6'b000000};

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_stall",   {26'd0, bus.o_stall}, 32'h0);
        chk("rst_flush",   {31'd0, bus.o_flush}, 32'h0);
        chk("rst_new_pc",  bus.o_new_pc, 32'h0);
        chk("rst_timeout", {31'd0, bus.o_stall_timeout}, 32'h0);
        chk("rst_scyc",    bus.o_stall_cycles, 32'h0);
        chk("rst_fcnt",    {16'd0, bus.o_flush_count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle
        repeat (3) tick();
        chk("idle_stall",   {26'd0, bus.o_stall}, 32'h0);
        chk("idle_flush",   {31'd0, bus.o_flush}, 32'h0);
        chk("idle_timeout", {31'd0, bus.o_stall_timeout}, 32'h0);

        // Vector table: each vector held for one edge, then a quiet gap
        for (int i = 0; i < 20; i++) begin
            set_req(vecs[i].req);
            bus.i_excp_valid = vecs[i].excp;
            #1;
            chk($sformatf("vec%0d_stall", i), {26'd0, bus.o_stall}, {26'd0, vecs[i].exp_stall});
            tick();
            set_req(4'b0000);
            bus.i_excp_valid = 1'b0;
            repeat (3) tick();
        end
        chk("vec_timeout", {31'd0, bus.o_stall_timeout}, 32'h0);

        // ID+MEM, then drop MEM within the same cycle
        set_req(4'b1010);
        #1;
        chk("idmem_stall", {26'd0, bus.o_stall}, 32'h1F);
        bus.i_stallreq_mem = 1'b0;
        #1;
        chk("id_only_stall", {26'd0, bus.o_stall}, 32'h07);
        tick();
        set_req(4'b0000);
        tick();

        // Exception with EX stall pending
        set_req(4'b0100);
        bus.i_excp_valid = 1'b1;
        bus.i_excp_eret  = 1'b0;
        #1;
        chk("exc_stall0", {26'd0, bus.o_stall}, 32'h0);
        tick();
        bus.i_excp_valid = 1'b0;
        #1;
        chk("exc_flush",     {31'd0, bus.o_flush}, 32'h1);
        chk("exc_new_pc",    bus.o_new_pc, 32'h20);
        chk("exc_fl_stall",  {26'd0, bus.o_stall}, 32'h0);
        tick();
        chk("exc_refill_st", {26'd0, bus.o_stall}, 32'h01);
        chk("exc_refill_fl", {31'd0, bus.o_flush}, 32'h0);
        tick();
        chk("exc_run_stall", {26'd0, bus.o_stall}, 32'h0F);
        set_req(4'b0000);
        tick();

        // ERET; a second exception asserted through FLUSH and REFILL is ignored
        fc_before = bus.o_flush_count;
        bus.i_excp_valid = 1'b1;
        bus.i_excp_eret  = 1'b1;
        bus.i_epc        = 32'h0000_1234;
        tick();
        bus.i_epc = 32'h0000_5678;
        #1;
        chk("eret_flush",  {31'd0, bus.o_flush}, 32'h1);
        chk("eret_new_pc", bus.o_new_pc, 32'h1234);
        tick();
        chk("ign_refill_stall", {26'd0, bus.o_stall}, 32'h01);
        chk("ign_refill_flush", {31'd0, bus.o_flush}, 32'h0);
        chk("ign_refill_pc",    bus.o_new_pc, 32'h1234);
        tick();
        bus.i_excp_valid = 1'b0;
        bus.i_excp_eret  = 1'b0;
        #1;
        chk("ign_run_flush", {31'd0, bus.o_flush}, 32'h0);
        chk("ign_run_stall", {26'd0, bus.o_stall}, 32'h0);
        chk("pc_hold",       bus.o_new_pc, 32'h1234);
`ifdef PIPE_CTRL_PERF_EN
        chk("fcnt_inc", {16'd0, bus.o_flush_count - fc_before}, 32'h1);
`else
        chk("fcnt_zero", {16'd0, bus.o_flush_count}, 32'h0);
        chk("scyc_zero", bus.o_stall_cycles, 32'h0);
`endif
        tick();

        // Watchdog: 7 stalled edges must not trip
        set_req(4'b0001);
        repeat (7) tick();
        set_req(4'b0000);
        tick();
        chk("wd7_timeout", {31'd0, bus.o_stall_timeout}, 32'h0);

        // Watchdog: trips on the 8th stalled edge and stays set
        set_req(4'b0001);
        repeat (7) tick();
        chk("wd_after7", {31'd0, bus.o_stall_timeout}, 32'h0);
        tick();
        chk("wd_after8", {31'd0, bus.o_stall_timeout}, 32'h1);
        set_req(4'b0000);
        repeat (3) tick();
        chk("wd_sticky", {31'd0, bus.o_stall_timeout}, 32'h1);

        // Reset during FLUSH: asynchronous drop, no REFILL afterwards
        bus.i_excp_valid = 1'b1;
        tick();
        bus.i_excp_valid = 1'b0;
        chk("rf_flush_pre", {31'd0, bus.o_flush}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rf_flush_async", {31'd0, bus.o_flush}, 32'h0);
        chk("rf_new_pc",      bus.o_new_pc, 32'h0);
        chk("rf_timeout",     {31'd0, bus.o_stall_timeout}, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rf_no_refill", {26'd0, bus.o_stall}, 32'h0);
        chk("rf_flush_post", {31'd0, bus.o_flush}, 32'h0);
        tick();
        chk("rf_idle_stall", {26'd0, bus.o_stall}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
